// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: FSM state codes,
// opcodes and the bit positions used on the TinyTapeout bidirectional pins.
package alu_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t EXEC     = 2'd1;
    localparam state_t MUL_LOOP = 2'd2;
    localparam state_t DONE     = 2'd3;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_LOAD = 3'd0;
    localparam opcode_t OP_ADD  = 3'd1;
    localparam opcode_t OP_SUB  = 3'd2;
    localparam opcode_t OP_AND  = 3'd3;
    localparam opcode_t OP_OR   = 3'd4;
    localparam opcode_t OP_XOR  = 3'd5;
    localparam opcode_t OP_SHL1 = 3'd6;
    localparam opcode_t OP_MUL  = 3'd7;

    localparam int UIO_START  = 0;
    localparam int UIO_OP_LSB = 1;
    localparam int UIO_BUSY   = 4;
    localparam int UIO_DONE   = 5;
    localparam int UIO_CARRY  = 6;
    localparam int UIO_ZERO   = 7;
    localparam int UIO_SEL_HI = 7;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    // Wide enough to hold the largest legal DW (8) as an iteration count.
    localparam int CNT_W = 4;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier step logic. The caller owns the {hi,acc}
// product register; this block owns the iteration counter and one step.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int DW = 8
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          start,
    input  logic          step,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] hi,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] next_acc,
    output logic [DW-1:0] next_hi,
    output logic          last
);

    logic [CNT_W-1:0] cnt;
    logic [DW:0]      sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ena) begin
            if (start) begin
                cnt <= CNT_W'(DW);
            end else if (step && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // The adder carry becomes the new MSB of hi as {hi,acc} shifts right.
    always_comb begin
        sum      = {1'b0, hi} + (acc[0] ? {1'b0, b} : '0);
        next_hi  = sum[DW:1];
        next_acc = {sum[0], acc[DW-1:1]};
    end

    assign last = step && (cnt == CNT_W'(1));

endmodule

// File: rtl/tt_um_alu_seq.sv
// TinyTapeout user top: opcode-driven accumulator ALU with a multi-cycle
// multiplier and a start/busy/done handshake on the uio pins.
module tt_um_alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DW     = 8,
    parameter int MUL_EN = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t        state;
    logic [DW-1:0] acc;
    logic [DW-1:0] hi;
    logic [DW-1:0] b_reg;
    opcode_t       op_reg;
    logic          carry;

    logic          start;
    logic          sel_hi;
    logic          busy;
    logic          done;
    logic          zero;

    logic [DW-1:0] alu_acc;
    logic          alu_carry;
    logic [DW:0]   alu_wide;

    logic          mul_start;
    logic          mul_step;
    logic [DW-1:0] mul_acc;
    logic [DW-1:0] mul_hi;
    logic          mul_last;

    logic [7:0]    sel_ext;
    logic          unused_pins;

    assign start  = uio_in[UIO_START];
    assign sel_hi = uio_in[UIO_SEL_HI];
    assign busy   = (state == EXEC) || (state == MUL_LOOP);
    assign done   = (state == DONE);
    assign zero   = (acc == '0);
    assign uio_oe = UIO_OE_MASK;

    assign unused_pins = ^{ui_in, uio_in[6:4]};

    assign mul_start = (state == EXEC) && (op_reg == OP_MUL) && (MUL_EN != 0);
    assign mul_step  = (state == MUL_LOOP);

    alu_seq_mul #(
        .DW(DW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (mul_start),
        .step    (mul_step),
        .acc     (acc),
        .hi      (hi),
        .b       (b_reg),
        .next_acc(mul_acc),
        .next_hi (mul_hi),
        .last    (mul_last)
    );

    // Single-cycle results; opcode 7 falls through as a hold (the MUL path
    // or the NOP when the multiplier is disabled).
    always_comb begin
        alu_wide  = '0;
        alu_acc   = acc;
        alu_carry = 1'b0;
        case (op_reg)
            OP_LOAD: alu_acc = b_reg;
            OP_ADD: begin
                alu_wide  = {1'b0, acc} + {1'b0, b_reg};
                alu_acc   = alu_wide[DW-1:0];
                alu_carry = alu_wide[DW];
            end
            OP_SUB: begin
                alu_wide  = {1'b0, acc} - {1'b0, b_reg};
                alu_acc   = alu_wide[DW-1:0];
                alu_carry = alu_wide[DW];
            end
            OP_AND:  alu_acc = acc & b_reg;
            OP_OR:   alu_acc = acc | b_reg;
            OP_XOR:  alu_acc = acc ^ b_reg;
            OP_SHL1: begin
                alu_acc   = {acc[DW-2:0], 1'b0};
                alu_carry = acc[DW-1];
            end
            default: begin
                alu_acc   = acc;
                alu_carry = carry;
            end
        endcase
    end

    always_comb begin
        sel_ext         = '0;
        sel_ext[DW-1:0] = sel_hi ? hi : acc;
    end

    always_comb begin
        uio_out            = '0;
        uio_out[UIO_BUSY]  = busy;
        uio_out[UIO_DONE]  = done;
        uio_out[UIO_CARRY] = carry;
        uio_out[UIO_ZERO]  = zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            hi     <= '0;
            b_reg  <= '0;
            op_reg <= OP_LOAD;
            carry  <= 1'b0;
            uo_out <= '0;
        end else if (ena) begin
            uo_out <= sel_ext;
            case (state)
                IDLE: begin
                    if (start) begin
                        b_reg  <= ui_in[DW-1:0];
                        op_reg <= uio_in[UIO_OP_LSB +: 3];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (mul_start) begin
                        hi    <= '0;
                        state <= MUL_LOOP;
                    end else begin
                        acc   <= alu_acc;
                        carry <= alu_carry;
                        state <= DONE;
                    end
                end
                MUL_LOOP: begin
                    acc <= mul_acc;
                    hi  <= mul_hi;
                    if (mul_last) begin
                        carry <= (mul_hi != '0);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_alu_seq.sv
// Self-checking bench for tt_um_alu_seq: an 8-bit instance tracked by a
// command-level model every cycle, plus a 4-bit instance with directed checks.
module tb_tt_um_alu_seq;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in8, uio_in8, uo_out8, uio_out8, uio_oe8;
    logic [7:0] ui_in4, uio_in4, uo_out4, uio_out4, uio_oe4;

    int checks;
    int failures;
    int cyc;
    int edges;
    int prev_cyc;
    logic check_en;

    tt_um_alu_seq #(.DW(8), .MUL_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in8), .uio_in(uio_in8),
        .uo_out(uo_out8), .uio_out(uio_out8), .uio_oe(uio_oe8)
    );

    tt_um_alu_seq #(.DW(4), .MUL_EN(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in4), .uio_in(uio_in4),
        .uo_out(uo_out4), .uio_out(uio_out4), .uio_oe(uio_oe4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Command-level model of the 8-bit instance: results come straight from
    // arithmetic at command acceptance and appear when the command completes.
    function automatic logic [16:0] model_op(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] h, input logic [7:0] b);
        int unsigned r_acc, r_hi, r_c, p;
        r_acc = a; r_hi = h; r_c = 0;
        case (op)
            3'd0: r_acc = b;
            3'd1: begin p = a + b; r_acc = p % 256; r_c = (p > 255); end
            3'd2: begin r_c = (b > a); r_acc = (a + 256 - b) % 256; end
            3'd3: r_acc = a & b;
            3'd4: r_acc = a | b;
            3'd5: r_acc = a ^ b;
            3'd6: begin r_c = a / 128; r_acc = (a * 2) % 256; end
            default: begin p = a * b; r_acc = p % 256; r_hi = p / 256; r_c = (r_hi != 0); end
        endcase
        return {r_c[0], r_hi[7:0], r_acc[7:0]};
    endfunction

    logic [7:0]  m_acc, m_hi, m_uo;
    logic        m_carry, m_in_done, m_uo_valid;
    logic [16:0] m_res;
    int          m_busy_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= 8'h00; m_hi <= 8'h00; m_carry <= 1'b0; m_res <= '0;
            m_busy_left <= 0; m_in_done <= 1'b0; m_uo <= 8'h00; m_uo_valid <= 1'b1;
        end else if (ena) begin
            m_uo       <= uio_in8[7] ? m_hi : m_acc;
            m_uo_valid <= (m_busy_left == 0);
            if (m_in_done) begin
                m_in_done <= 1'b0;
            end else if (m_busy_left > 0) begin
                if (m_busy_left == 1) begin
                    m_acc     <= m_res[7:0];
                    m_hi      <= m_res[15:8];
                    m_carry   <= m_res[16];
                    m_in_done <= 1'b1;
                end
                m_busy_left <= m_busy_left - 1;
            end else if (uio_in8[0]) begin
                m_res       <= model_op(uio_in8[3:1], m_acc, m_hi, ui_in8);
                m_busy_left <= (uio_in8[3:1] == 3'd7) ? 9 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("busy8", uio_out8[4], m_busy_left != 0);
            checkOutput("done8", uio_out8[5], m_in_done);
            checkOutput("carry8", uio_out8[6], m_carry);
            checkOutput("low_uio8", uio_out8[3:0], 4'h0);
            checkOutput("oe8", uio_oe8, 8'hF0);
            if (m_busy_left == 0) checkOutput("zero8", uio_out8[7], m_acc == 8'h00);
            if (m_uo_valid) checkOutput("uo8", uo_out8, m_uo);
        end
    end

    task automatic applyStimulus(input int which, input logic [2:0] op, input logic [7:0] b);
        if (which == 0) begin
            ui_in8 = b; uio_in8 = {uio_in8[7], 3'b000, op, 1'b1};
        end else begin
            ui_in4 = b; uio_in4 = {uio_in4[7], 3'b000, op, 1'b1};
        end
        @(posedge clk); #1;
        if (which == 0) uio_in8[0] = 1'b0;
        else uio_in4[0] = 1'b0;
    endtask

    task automatic wait_done(input int which, output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            n++;
            if ((which == 0) ? uio_out8[5] : uio_out4[5]) return;
        end
        checkOutput("done_timeout", 0, 1);
    endtask

    task automatic do_cmd(input int which, input logic [2:0] op, input logic [7:0] b,
                          input int want_cycle, input string name);
        int n;
        applyStimulus(which, op, b);
        wait_done(which, n);
        checkOutput({name, "_done_cycle"}, n + 1, want_cycle);
        @(posedge clk); #1;
    endtask

    task automatic set_sel(input int which, input logic s);
        if (which == 0) uio_in8[7] = s;
        else uio_in4[7] = s;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] uo;
        logic       c;
        int         cyc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{OP_LOAD, 8'hF0, 8'hF0, 1'b0, 2};
        vecs[1]  = '{OP_ADD,  8'h20, 8'h10, 1'b1, 2};
        vecs[2]  = '{OP_SUB,  8'h11, 8'hFF, 1'b1, 2};
        vecs[3]  = '{OP_XOR,  8'hFF, 8'h00, 1'b0, 2};
        vecs[4]  = '{OP_LOAD, 8'h3C, 8'h3C, 1'b0, 2};
        vecs[5]  = '{OP_AND,  8'h0F, 8'h0C, 1'b0, 2};
        vecs[6]  = '{OP_OR,   8'hA0, 8'hAC, 1'b0, 2};
        vecs[7]  = '{OP_SHL1, 8'h00, 8'h58, 1'b1, 2};
        vecs[8]  = '{OP_SHL1, 8'h00, 8'hB0, 1'b0, 2};
        vecs[9]  = '{OP_LOAD, 8'h0D, 8'h0D, 1'b0, 2};
        vecs[10] = '{OP_MUL,  8'h0B, 8'h8F, 1'b0, 10};
        vecs[11] = '{OP_LOAD, 8'hFF, 8'hFF, 1'b0, 2};
        vecs[12] = '{OP_MUL,  8'hFF, 8'h01, 1'b1, 10};

        checks = 0; failures = 0; cyc = 0; check_en = 1'b0;
        rst_n = 1'b0; ena = 1'b1;
        ui_in8 = 8'h00; uio_in8 = 8'h00; ui_in4 = 8'h00; uio_in4 = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_uo", uo_out8, 8'h00);
        checkOutput("reset_uio", uio_out8, 8'h80);
        checkOutput("reset_oe", uio_oe8, 8'hF0);
        rst_n = 1'b1;
        check_en = 1'b1;

        // LOAD: one busy cycle, done on cycle 2, result visible afterwards.
        applyStimulus(0, OP_LOAD, 8'h25);
        checkOutput("load_busy", uio_out8[4], 1'b1);
        wait_done(0, edges);
        checkOutput("load_done_cycle", edges + 1, 2);
        checkOutput("load_done_busy", uio_out8[4], 1'b0);
        @(posedge clk); #1;
        checkOutput("load_uo", uo_out8, 8'h25);
        checkOutput("load_flags", uio_out8, 8'h00);

        for (int i = 0; i < 13; i++) begin
            do_cmd(0, vecs[i].op, vecs[i].b, vecs[i].cyc, "vec");
            checkOutput("vec_uo", uo_out8, vecs[i].uo);
            checkOutput("vec_carry", uio_out8[6], vecs[i].c);
            checkOutput("vec_zero", uio_out8[7], vecs[i].uo == 8'h00);
            if (i == 10) begin
                set_sel(0, 1'b1);
                checkOutput("mul_small_hi", uo_out8, 8'h00);
                set_sel(0, 1'b0);
            end
        end
        set_sel(0, 1'b1);
        checkOutput("mul_big_hi", uo_out8, 8'hFE);
        set_sel(0, 1'b0);
        do_cmd(0, OP_LOAD, 8'h42, 2, "load_keeps_hi");
        set_sel(0, 1'b1);
        checkOutput("hi_kept", uo_out8, 8'hFE);
        set_sel(0, 1'b0);

        // Held start: back-to-back commands every 3 cycles, start toggled while busy.
        ui_in8 = 8'h01; uio_in8 = {1'b0, 3'b000, OP_LOAD, 1'b1};
        @(posedge clk); #1;
        uio_in8[3:1] = OP_ADD; uio_in8[0] = 1'b0;
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            wait_done(0, edges);
            uio_in8[0] = 1'b1;
            if (k > 0) checkOutput("b2b_interval", cyc - prev_cyc, 3);
            prev_cyc = cyc;
            @(posedge clk); #1;
            checkOutput("b2b_acc", uo_out8, k + 1);
            if (k == 2) begin
                uio_in8[0] = 1'b0;
            end else begin
                @(posedge clk); #1;
                uio_in8[0] = 1'b0;
            end
        end

        // Clock enable: a start during ena=0 is not seen; a frozen MUL resumes intact.
        do_cmd(0, OP_LOAD, 8'h0D, 2, "ena_load");
        ena = 1'b0;
        ui_in8 = 8'h77; uio_in8 = {1'b0, 3'b000, OP_LOAD, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        uio_in8[0] = 1'b0;
        ena = 1'b1;
        @(posedge clk); #1;
        checkOutput("ena_start_ignored", uo_out8, 8'h0D);
        applyStimulus(0, OP_MUL, 8'h0B);
        repeat (3) @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ena_frozen_busy", uio_out8[5:4], 2'b01);
        ena = 1'b1;
        wait_done(0, edges);
        checkOutput("ena_mul_done_cycle", 3 + 5 + edges + 1, 15);
        @(posedge clk); #1;
        checkOutput("ena_mul_uo", uo_out8, 8'h8F);

        // Asynchronous reset in the middle of the multiply loop.
        do_cmd(0, OP_LOAD, 8'h33, 2, "rst_load");
        applyStimulus(0, OP_MUL, 8'h07);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_uo", uo_out8, 8'h00);
        checkOutput("async_rst_uio", uio_out8, 8'h80);
        checkOutput("async_rst_uio4", uio_out4, 8'h80);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_cmd(0, OP_LOAD, 8'h5A, 2, "post_rst_load");
        checkOutput("post_rst_uo", uo_out8, 8'h5A);

        // Narrow instance: upper output bits stay zero and results wrap at 4 bits.
        do_cmd(1, OP_LOAD, 8'hFF, 2, "dw4_load");
        checkOutput("dw4_load_uo", uo_out4, 8'h0F);
        do_cmd(1, OP_ADD, 8'h01, 2, "dw4_add");
        checkOutput("dw4_add_uo", uo_out4, 8'h00);
        checkOutput("dw4_add_flags", uio_out4, 8'hC0);
        do_cmd(1, OP_LOAD, 8'h0F, 2, "dw4_load2");
        do_cmd(1, OP_MUL, 8'h0F, 6, "dw4_mul");
        checkOutput("dw4_mul_uo", uo_out4, 8'h01);
        checkOutput("dw4_mul_carry", uio_out4[6], 1'b1);
        set_sel(1, 1'b1);
        checkOutput("dw4_mul_hi", uo_out4, 8'h0E);
        checkOutput("dw4_oe", uio_oe4, 8'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
